// File: rtl/dec_scan_n.sv
// rtl/dec_scan_n.sv - registered N-to-2^N decoder with direct select and auto-scan modes
module dec_scan_n #(
    parameter int IN_W       = 3,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 0,
    localparam int OUT_W     = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [IN_W-1:0]  in,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] out,
    output logic [IN_W-1:0]  idx,
    output logic             valid,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [OUT_W-1:0] POLARITY = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [IN_W-1:0]  idx_nxt;
    logic             valid_nxt;
    logic             wrap_nxt;
    logic [OUT_W-1:0] onehot_nxt;
    logic [OUT_W-1:0] out_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        if (en) begin
            valid_nxt = 1'b1;
            if (!mode) begin
                state_nxt = DIRECT;
                idx_nxt   = in;
            end else begin
                state_nxt = SCAN;
                // Entering scan restarts at index 0 without flagging a wrap.
                if (state == SCAN) begin
                    // >= rather than == so lowering div below cnt advances at once.
                    if (cnt >= div) begin
                        cnt_nxt  = '0;
                        idx_nxt  = idx + 1'b1;
                        wrap_nxt = &idx;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        idx_nxt = idx;
                    end
                end
            end
        end
        onehot_nxt = valid_nxt ? ({{(OUT_W-1){1'b0}}, 1'b1} << idx_nxt) : '0;
        out_nxt    = onehot_nxt ^ POLARITY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            out   <= POLARITY;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
            out   <= out_nxt;
        end
    end

endmodule

// File: tb/tb_dec_scan_n.sv
// tb/tb_dec_scan_n.sv - self-checking bench for dec_scan_n against a cycle-level reference model
module tb_dec_scan_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  in;
    logic [15:0] div;
    logic [7:0]  out;
    logic [2:0]  idx;
    logic        valid;
    logic        wrap;

    logic        en_b;
    logic        mode_b;
    logic [1:0]  in_b;
    logic [15:0] div_b;
    logic [3:0]  out_b;
    logic [1:0]  idx_b;
    logic        valid_b;
    logic        wrap_b;

    int checks = 0;
    int errors = 0;

    // Reference model: the index shown, and how many cycles it has been shown.
    bit m_scanning;
    int m_idx;
    int m_age;
    bit m_valid;
    bit m_wrap;

    always #5 clk = ~clk;

    dec_scan_n #(.IN_W(3), .DIV_W(16), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .div(div),
        .out(out), .idx(idx), .valid(valid), .wrap(wrap)
    );

    dec_scan_n #(.IN_W(2), .DIV_W(16), .ACTIVE_LOW(1)) dut_low (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .in(in_b), .div(div_b),
        .out(out_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scanning = 1'b0;
        m_idx      = 0;
        m_age      = 0;
        m_valid    = 1'b0;
        m_wrap     = 1'b0;
    endtask

    task automatic model_step();
        m_wrap = 1'b0;
        if (!en) begin
            m_scanning = 1'b0;
            m_idx      = 0;
            m_valid    = 1'b0;
        end else if (!mode) begin
            m_scanning = 1'b0;
            m_idx      = int'(in);
            m_valid    = 1'b1;
        end else if (!m_scanning) begin
            m_scanning = 1'b1;
            m_idx      = 0;
            m_age      = 1;
            m_valid    = 1'b1;
        end else if (m_age >= int'(div) + 1) begin
            m_idx  = (m_idx + 1) % 8;
            m_age  = 1;
            m_wrap = (m_idx == 0);
        end else begin
            m_age++;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_out;
        exp_out = m_valid ? (32'd1 << m_idx) : 32'd0;
        check("out", {24'd0, out}, exp_out);
        check("idx", {29'd0, idx}, m_idx);
        check("valid", {31'd0, valid}, {31'd0, m_valid});
        check("wrap", {31'd0, wrap}, {31'd0, m_wrap});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int wraps;
        logic [7:0] one;
        one    = 8'd1;
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        in     = '0;
        div    = '0;
        en_b   = 1'b0;
        mode_b = 1'b0;
        in_b   = '0;
        div_b  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("low_reset_out", {28'd0, out_b}, 32'hF);
        rst_n = 1'b1;

        en   = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            cycle();
            check("direct_sweep", {24'd0, out}, {24'd0, one << i});
        end
        en = 1'b0;
        in = 3'd5;
        cycle();
        check("direct_disabled", {24'd0, out}, 32'h0);

        en   = 1'b1;
        mode = 1'b1;
        div  = 16'd2;
        cycle();
        check("scan_entry_wrap", {31'd0, wrap}, 32'd0);
        wraps = 0;
        repeat (48) begin
            cycle();
            wraps += int'(wrap);
        end
        check("wraps_div2", wraps, 2);

        mode = 1'b0;
        cycle();
        mode = 1'b1;
        div  = 16'd0;
        cycle();
        wraps = 0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("walk_div0", {24'd0, out}, {24'd0, one << (k % 8)});
            wraps += int'(wrap);
        end
        check("wraps_div0", wraps, 2);

        mode = 1'b0;
        div  = 16'd100;
        cycle();
        mode = 1'b1;
        cycle();
        repeat (50) cycle();
        div = 16'd10;
        cycle();
        check("div_lowered_advance", {29'd0, idx}, 32'd1);
        repeat (10) cycle();
        check("div10_hold", {29'd0, idx}, 32'd1);
        cycle();
        check("div10_step", {29'd0, idx}, 32'd2);

        div  = 16'd0;
        mode = 1'b0;
        cycle();
        mode = 1'b1;
        cycle();
        repeat (5) cycle();
        check("scan_at_5", {29'd0, idx}, 32'd5);
        mode = 1'b0;
        in   = 3'd3;
        cycle();
        check("scan_to_direct_out", {24'd0, out}, 32'h08);
        check("scan_to_direct_wrap", {31'd0, wrap}, 32'd0);

        mode = 1'b1;
        repeat (3) cycle();
        rst_n = 1'b0;
        #2;
        check("async_rst_out", {24'd0, out}, 32'h0);
        check("async_rst_valid", {31'd0, valid}, 32'd0);
        check("async_rst_idx", {29'd0, idx}, 32'd0);
        check("async_rst_wrap", {31'd0, wrap}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        en_b   = 1'b1;
        mode_b = 1'b0;
        in_b   = 2'd2;
        cycle();
        check("low_direct_2", {28'd0, out_b}, 32'hB);
        en_b = 1'b0;
        cycle();
        check("low_disabled", {28'd0, out_b}, 32'hF);

        repeat (400) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = ($urandom_range(0, 3) != 0);
            in   = 3'($urandom);
            div  = 16'($urandom_range(0, 4));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
